// File: rtl/i2c_command_sequencer.sv
// Command FIFO plus issue/response FSM that drives an I2C master's enable/busy
// handshake and returns one response beat (read data, timeout flag) per command.
module i2c_command_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int REGISTER_WIDTH = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int FIFO_DEPTH     = 4,
  parameter int START_TIMEOUT  = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_read_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_device_address,
  input  logic [REGISTER_WIDTH-1:0]     cmd_register_address,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_read_write,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  output logic                          master_enable,
  output logic                          master_read_write,
  output logic [ADDR_WIDTH-1:0]         master_device_address,
  output logic [REGISTER_WIDTH-1:0]     master_register_address,
  output logic [DATA_WIDTH-1:0]         master_mosi_data,
  input  logic                          master_busy,
  input  logic [DATA_WIDTH-1:0]         master_miso_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TO_W    = $clog2(START_TIMEOUT);
  localparam int ENTRY_W = 1 + ADDR_WIDTH + REGISTER_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESPOND} state_t;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [TO_W-1:0]           timer_q, timer_d;
  logic                      enable_q, enable_d;
  logic                      mrw_q, mrw_d;
  logic [ADDR_WIDTH-1:0]     mdev_q, mdev_d;
  logic [REGISTER_WIDTH-1:0] mreg_q, mreg_d;
  logic [DATA_WIDTH-1:0]     mdata_q, mdata_d;
  logic                      rsp_rw_q, rsp_rw_d;
  logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                      rsp_to_q, rsp_to_d;

  logic                      push, pop;
  logic                      head_rw;
  logic [ADDR_WIDTH-1:0]     head_dev;
  logic [REGISTER_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0]     head_data;

  assign cmd_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign {head_rw, head_dev, head_reg, head_data} = fifo_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    enable_d   = enable_q;
    mrw_d      = mrw_q;
    mdev_d     = mdev_q;
    mreg_d     = mreg_q;
    mdata_d    = mdata_q;
    rsp_rw_d   = rsp_rw_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A busy level left over from another agent holds off the launch.
        if (count_q != '0 && !master_busy) begin
          pop      = 1'b1;
          mrw_d    = head_rw;
          mdev_d   = head_dev;
          mreg_d   = head_reg;
          mdata_d  = head_data;
          timer_d  = '0;
          enable_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (master_busy) begin
          enable_d = 1'b0;
          state_d  = S_WAIT_DONE;
        end else if (timer_q == TO_W'(START_TIMEOUT - 1)) begin
          enable_d   = 1'b0;
          rsp_rw_d   = mrw_q;
          rsp_data_d = '0;
          rsp_to_d   = 1'b1;
          state_d    = S_RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!master_busy) begin
          rsp_rw_d   = mrw_q;
          rsp_data_d = mrw_q ? master_miso_data : '0;
          rsp_to_d   = 1'b0;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_read_write, cmd_device_address,
                                     cmd_register_address, cmd_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      enable_q   <= 1'b0;
      mrw_q      <= 1'b0;
      mdev_q     <= '0;
      mreg_q     <= '0;
      mdata_q    <= '0;
      rsp_rw_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      enable_q   <= enable_d;
      mrw_q      <= mrw_d;
      mdev_q     <= mdev_d;
      mreg_q     <= mreg_d;
      mdata_q    <= mdata_d;
      rsp_rw_q   <= rsp_rw_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  assign rsp_valid               = (state_q == S_RESPOND);
  assign rsp_read_write          = rsp_rw_q;
  assign rsp_data                = rsp_data_q;
  assign rsp_timeout             = rsp_to_q;
  assign master_enable           = enable_q;
  assign master_read_write       = mrw_q;
  assign master_device_address   = mdev_q;
  assign master_register_address = mreg_q;
  assign master_mosi_data        = mdata_q;
  assign fifo_count              = count_q;
  assign idle                    = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_i2c_command_sequencer.sv
// Directed bench for i2c_command_sequencer with a small reactive I2C master model
// whose read data is the register address XOR 8'h04.
module tb_i2c_command_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_read_write;
  logic [6:0] cmd_device_address;
  logic [7:0] cmd_register_address, cmd_data;
  logic       rsp_valid, rsp_ready, rsp_read_write, rsp_timeout;
  logic [7:0] rsp_data;
  logic       master_enable, master_read_write, master_busy;
  logic [6:0] master_device_address;
  logic [7:0] master_register_address, master_mosi_data, master_miso_data;
  logic [2:0] fifo_count;
  logic       idle;

  int checks = 0;
  int errors = 0;

  // master model controls
  logic m_on = 1'b0;
  logic m_stall = 1'b0;
  int   m_delay = 3;
  int   m_hold = 20;
  int   m_state = 0;
  int   m_cnt = 0;

  always #5 clock = ~clock;

  i2c_command_sequencer #(
    .DATA_WIDTH(8), .REGISTER_WIDTH(8), .ADDR_WIDTH(7),
    .FIFO_DEPTH(4), .START_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read_write(cmd_read_write), .cmd_device_address(cmd_device_address),
    .cmd_register_address(cmd_register_address), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read_write(rsp_read_write), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .master_enable(master_enable), .master_read_write(master_read_write),
    .master_device_address(master_device_address),
    .master_register_address(master_register_address),
    .master_mosi_data(master_mosi_data), .master_busy(master_busy),
    .master_miso_data(master_miso_data), .fifo_count(fifo_count), .idle(idle)
  );

  // Busy rises m_delay cycles after enable is seen, stays m_hold cycles.
  initial begin
    master_busy = 1'b0;
    master_miso_data = 8'h00;
    forever begin
      @(negedge clock);
      case (m_state)
        0: begin
          master_busy = m_stall;
          if (m_on && !m_stall && master_enable) begin
            m_cnt = 0;
            m_state = 1;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == m_delay) begin
            master_busy = 1'b1;
            master_miso_data = master_register_address ^ 8'h04;
            m_cnt = 0;
            m_state = 2;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == m_hold) begin
            master_busy = 1'b0;
            m_state = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] dat);
    cmd_valid = 1'b1;
    cmd_read_write = rw;
    cmd_device_address = dev;
    cmd_register_address = rg;
    cmd_data = dat;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) check({tag, "_accept"}, cmd_ready, 1);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic rw, input logic [6:0] dev,
                      input logic [7:0] rg, input logic [7:0] dat);
    drive_cmd(rw, dev, rg, dat);
    wait_accept(tag);
  endtask

  task automatic count_enable(output int n, output logic stable);
    int w = 0;
    logic [23:0] f0;
    n = 0;
    stable = 1'b1;
    while (!master_enable && w < 400) begin
      @(negedge clock);
      w++;
    end
    f0 = {master_read_write, master_device_address, master_register_address, master_mosi_data};
    while (master_enable && n < 400) begin
      if ({master_read_write, master_device_address, master_register_address,
           master_mosi_data} !== f0) stable = 1'b0;
      n++;
      @(negedge clock);
    end
  endtask

  task automatic collect(input string tag, input logic rw, input logic [7:0] dat,
                         input logic to);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_rw"}, rsp_read_write, rw);
    check({tag, "_data"}, rsp_data, dat);
    check({tag, "_timeout"}, rsp_timeout, to);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, "_drop"}, rsp_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_fields"}, {rsp_read_write, rsp_data, rsp_timeout}, 0);
    check({tag, "_enable"}, master_enable, 0);
    check({tag, "_master_fields"}, {master_read_write, master_device_address,
                                    master_register_address, master_mosi_data}, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    int          n;
    logic        st;
    int          bp_bad, bp_en;
    logic [10:0] snap;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_read_write = 1'b0;
    cmd_device_address = 7'h00;
    cmd_register_address = 8'h00;
    cmd_data = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clock);

    // Write: busy 3 cycles after enable -> enable high 4 cycles
    m_on = 1'b1; m_delay = 3; m_hold = 20;
    push("wr", 1'b0, 7'h50, 8'h10, 8'hA5);
    count_enable(n, st);
    check("wr_enable_cycles", n, 4);
    check("wr_fields_stable", st, 1);
    check("wr_fields", {master_read_write, master_device_address, master_register_address,
                        master_mosi_data}, {1'b0, 7'h50, 8'h10, 8'hA5});
    collect("wr_rsp", 1'b0, 8'h00, 1'b0);
    check("wr_idle", idle, 1);

    // Read: model returns 75^04 = 71
    push("rd", 1'b1, 7'h68, 8'h75, 8'h00);
    collect("rd_rsp", 1'b1, 8'h71, 1'b0);

    // FIFO full with stale busy blocking the launch
    m_hold = 5;
    m_stall = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 4; i++) push("full", 1'b1, 7'h30, 8'h20 + 8'(i), 8'h00);
    check("full_ready", cmd_ready, 0);
    check("full_count", fifo_count, 4);
    check("full_no_enable", master_enable, 0);
    drive_cmd(1'b1, 7'h30, 8'h24, 8'h00);
    repeat (3) @(negedge clock);
    check("full_5th_held", fifo_count, 4);
    m_stall = 1'b0;
    wait_accept("full5");
    collect("full_rsp0", 1'b1, 8'h24, 1'b0);
    collect("full_rsp1", 1'b1, 8'h25, 1'b0);
    collect("full_rsp2", 1'b1, 8'h26, 1'b0);
    collect("full_rsp3", 1'b1, 8'h27, 1'b0);
    collect("full_rsp4", 1'b1, 8'h20, 1'b0);

    // Timeout: busy never rises, START_TIMEOUT = 8
    m_on = 1'b0;
    m_stall = 1'b1;
    @(negedge clock);
    push("to", 1'b0, 7'h11, 8'h22, 8'h33);
    push("to", 1'b1, 7'h12, 8'h34, 8'h00);
    m_stall = 1'b0;
    count_enable(n, st);
    check("to_enable_cycles", n, 8);
    check("to_rsp_next", rsp_valid, 1);
    collect("to_rsp0", 1'b0, 8'h00, 1'b1);
    count_enable(n, st);
    check("to2_enable_cycles", n, 8);
    check("to2_reg", master_register_address, 8'h34);
    collect("to_rsp1", 1'b1, 8'h00, 1'b1);

    // Backpressure: response pending 50 cycles while the FIFO fills
    m_on = 1'b1;
    push("bp", 1'b1, 7'h40, 8'h40, 8'h00);
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    snap = {rsp_valid, rsp_read_write, rsp_data, rsp_timeout};
    bp_bad = 0;
    bp_en = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 4) drive_cmd(1'b1, 7'h41, 8'h50 + 8'(i), 8'h00);
      else cmd_valid = 1'b0;
      @(negedge clock);
      if ({rsp_valid, rsp_read_write, rsp_data, rsp_timeout} !== snap) bp_bad++;
      if (master_enable) bp_en++;
    end
    check("bp_rsp_stable", bp_bad, 0);
    check("bp_no_enable", bp_en, 0);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_ready", cmd_ready, 0);
    collect("bp_rsp0", 1'b1, 8'h44, 1'b0);
    collect("bp_rsp1", 1'b1, 8'h54, 1'b0);
    collect("bp_rsp2", 1'b1, 8'h55, 1'b0);
    collect("bp_rsp3", 1'b1, 8'h56, 1'b0);
    collect("bp_rsp4", 1'b1, 8'h57, 1'b0);

    // Reset during S_WAIT_DONE with two commands queued
    m_hold = 40;
    push("rst", 1'b0, 7'h60, 8'h01, 8'h11);
    push("rst", 1'b0, 7'h61, 8'h02, 8'h22);
    push("rst", 1'b0, 7'h62, 8'h03, 8'h33);
    count_enable(n, st);
    check("rst_queued", fifo_count, 2);
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("rst_mid");
    reset = 1'b0;
    bp_bad = 0;
    bp_en = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (rsp_valid) bp_bad++;
      if (master_enable) bp_en++;
    end
    check("rst_no_rsp", bp_bad, 0);
    check("rst_no_enable", bp_en, 0);
    check("rst_end_count", fifo_count, 0);
    check("rst_end_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
